// File: rtl/mau_pkg.sv
// Shared encodings for the MEM-stage access unit: op codes, FSM states,
// byte-enable masks and a lane-mask helper.
package mau_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Expand a 4-bit byte-enable into a 32-bit data mask.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? 8'hff : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundles for the access unit: pipeline op/response side and data-memory side.
interface mau_op_if;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        misalign;
    logic        err;

    modport master (output op_valid, op_type, addr, wdata, pc,
                    input  op_ready, rsp_valid, rdata, misalign, err);
    modport slave  (input  op_valid, op_type, addr, wdata, pc,
                    output op_ready, rsp_valid, rdata, misalign, err);
endinterface

interface mau_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/mau_lane_fmt.sv
// Combinational lane formatter: byte enables, store replication, load
// extract/extend and alignment check from op type and the low address bits.
module mau_lane_fmt
    import mau_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        is_store
);

    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign shifted_s = rword >> {lane, 3'b000};
    assign byte_s    = shifted_s[7:0];
    assign half_s    = lane[1] ? rword[31:16] : rword[15:0];

    // Size-dependent lane mask, replication and alignment
    always_comb begin
        be        = BE_NONE;
        wdata_rep = 32'd0;
        misalign  = 1'b0;
        is_store  = 1'b0;
        load_data = 32'd0;
        case (op)
            OP_LW, OP_SW: begin
                be        = BE_WORD;
                misalign  = (lane != 2'd0);
                wdata_rep = wdata;
                load_data = rword;
            end
            OP_LH, OP_LHU, OP_SH: begin
                be        = BE_HALF << {lane[1], 1'b0};
                misalign  = lane[0];
                wdata_rep = {2{wdata[15:0]}};
                load_data = (op == OP_LH) ? {{16{half_s[15]}}, half_s} : {16'd0, half_s};
            end
            OP_LB, OP_LBU, OP_SB: begin
                be        = BE_BYTE << lane;
                wdata_rep = {4{wdata[7:0]}};
                load_data = (op == OP_LB) ? {{24{byte_s[7]}}, byte_s} : {24'd0, byte_s};
            end
            default: begin
                be        = BE_NONE;
                wdata_rep = 32'd0;
                load_data = 32'd0;
            end
        endcase
        is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: accepts one load/store from the pipeline, issues a
// word-aligned memory request with timeout, and returns formatted load data.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3fff,
    parameter logic [7:0]  TIMEOUT    = 8'd255
) (
    input  logic      clk,
    input  logic      reset,
    mau_op_if.slave   op,
    mau_mem_if.master mem
);

    state_e      state_r;
    op_e         op_r;
    logic [1:0]  lane_r;
    logic [31:0] pc_r;
    logic [7:0]  cnt_r;
    logic        op_ready_r, rsp_valid_r, misalign_r, err_r;
    logic [31:0] rdata_r;
    logic        mem_req_r, mem_we_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_addr_r, mem_wdata_r;

    op_e         fmt_op_s;
    logic [1:0]  fmt_lane_s;
    logic [3:0]  fmt_be_s;
    logic [31:0] fmt_wdata_s, fmt_load_s;
    logic        fmt_misalign_s, fmt_is_store_s, range_err_s;

    // Formatter sees the live op while idle, the latched op while waiting on memory
    always_comb begin
        if (state_r == ST_IDLE) begin
            fmt_op_s   = op_e'(op.op_type);
            fmt_lane_s = op.addr[1:0];
        end else begin
            fmt_op_s   = op_r;
            fmt_lane_s = lane_r;
        end
    end

    assign range_err_s = (op.addr > ADDR_LIMIT);

    mau_lane_fmt u_fmt (
        .op        (fmt_op_s),
        .lane      (fmt_lane_s),
        .wdata     (op.wdata),
        .rword     (mem.mem_rdata),
        .be        (fmt_be_s),
        .wdata_rep (fmt_wdata_s),
        .load_data (fmt_load_s),
        .misalign  (fmt_misalign_s),
        .is_store  (fmt_is_store_s)
    );

    // Control FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_LW;
            lane_r      <= 2'd0;
            pc_r        <= 32'd0;
            cnt_r       <= 8'd0;
            op_ready_r  <= 1'b1;
            rsp_valid_r <= 1'b0;
            rdata_r     <= 32'd0;
            misalign_r  <= 1'b0;
            err_r       <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= BE_NONE;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid_r <= 1'b0;
                    rdata_r     <= 32'd0;
                    misalign_r  <= 1'b0;
                    err_r       <= 1'b0;
                    if (op.op_valid) begin
                        op_ready_r <= 1'b0;
                        op_r       <= fmt_op_s;
                        lane_r     <= op.addr[1:0];
                        pc_r       <= op.pc;
                        // Misalignment wins over range; faulted ops skip memory entirely
                        if (fmt_misalign_s || range_err_s) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            misalign_r  <= fmt_misalign_s;
                            err_r       <= ~fmt_misalign_s;
                        end else begin
                            state_r     <= ST_REQ;
                            cnt_r       <= 8'd0;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= fmt_is_store_s;
                            mem_be_r    <= fmt_be_s;
                            mem_addr_r  <= {op.addr[31:2], 2'b00};
                            mem_wdata_r <= fmt_wdata_s;
                        end
                    end else begin
                        op_ready_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        state_r     <= ST_RESP;
                        mem_req_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rdata_r     <= mem_we_r ? 32'd0 : fmt_load_s;
                    end else if (cnt_r == TIMEOUT) begin
                        state_r     <= ST_RESP;
                        mem_req_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        err_r       <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    op_ready_r  <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rdata_r     <= 32'd0;
                    misalign_r  <= 1'b0;
                    err_r       <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    op_ready_r  <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    mem_req_r   <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Store trace at the accepting edge; the written word shows only enabled lanes
    always_ff @(posedge clk) begin
        if (!reset && state_r == ST_REQ && mem.mem_ack && mem_we_r) begin
            $display("%d@%h: *%h <= %h", $time, pc_r, mem_addr_r,
                     mem_wdata_r & be_mask(mem_be_r));
        end
    end
`endif

    assign op.op_ready  = op_ready_r;
    assign op.rsp_valid = rsp_valid_r;
    assign op.rdata     = rdata_r;
    assign op.misalign  = misalign_r;
    assign op.err       = err_r;
    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_be    = mem_be_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-level
// reference model of memory, lane formatting, faults and timeout.
module tb_mem_access_unit;

    localparam logic [2:0]  T_LW = 3'd0, T_LH = 3'd1, T_LHU = 3'd2, T_LB = 3'd3;
    localparam logic [2:0]  T_LBU = 3'd4, T_SW = 3'd5, T_SH = 3'd6, T_SB = 3'd7;
    localparam logic [31:0] LIMIT = 32'h0000_3fff;
    localparam int          TMO   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [31:0] last_rd;
    logic [31:0] mem_m [int unsigned];

    mau_op_if  opif();
    mau_mem_if memif();

    mem_access_unit #(.ADDR_LIMIT(LIMIT), .TIMEOUT(8'd4)) dut (
        .clk   (clk),
        .reset (reset),
        .op    (opif),
        .mem   (memif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] t);
        if (t == T_LW || t == T_SW) return 4;
        if (t == T_LH || t == T_LHU || t == T_SH) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] rd_word(input int unsigned idx);
        if (mem_m.exists(idx)) return mem_m[idx];
        return (idx * 32'h9e37_79b1) ^ 32'h5a5a_0f0f;
    endfunction

    task automatic run_op(input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input int wt);
        int nb, cyc, req_n, exp_lat, exp_req, sh;
        logic exp_mis, exp_err, fault, is_st, done;
        logic [31:0] word, exp_rd, exp_wd, v;
        logic [3:0] exp_be;
        int unsigned idx;

        nb      = nbytes(t);
        is_st   = (t == T_SW) || (t == T_SH) || (t == T_SB);
        exp_mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'd0);
        exp_err = !exp_mis && (a > LIMIT);
        fault   = exp_mis || exp_err;
        idx     = a >> 2;
        word    = rd_word(idx);
        sh      = int'(a[1:0]);
        exp_be  = 4'(((1 << nb) - 1) << sh);
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
        exp_rd = 32'd0;
        if (fault) begin
            exp_lat = 1; exp_req = 0;
        end else if (wt > TMO) begin
            exp_err = 1'b1; exp_lat = TMO + 2; exp_req = TMO + 1;
        end else begin
            exp_lat = wt + 2; exp_req = wt + 1;
            if (!is_st) begin
                v = word >> (8 * sh);
                if (nb == 1) exp_rd = (t == T_LB && v[7]) ? (v & 32'hff) | 32'hffff_ff00 : v & 32'hff;
                else if (nb == 2) exp_rd = (t == T_LH && v[15]) ? (v & 32'hffff) | 32'hffff_0000 : v & 32'hffff;
                else exp_rd = word;
            end
        end

        @(negedge clk);
        chk("op_ready", {31'd0, opif.op_ready}, 32'd1);
        opif.op_valid = 1'b1; opif.op_type = t; opif.addr = a;
        opif.wdata = wd; opif.pc = $urandom;
        @(negedge clk);
        opif.op_valid = 1'b0; opif.addr = $urandom; opif.wdata = $urandom;
        cyc = 1; req_n = 0; done = 1'b0;
        while (!done && cyc <= 40) begin
            memif.mem_ack = 1'b0;
            memif.mem_rdata = $urandom;
            if (memif.mem_req) begin
                if (req_n == 0) begin
                    chk("mem_be", {28'd0, memif.mem_be}, {28'd0, exp_be});
                    chk("mem_addr", memif.mem_addr, a & 32'hffff_fffc);
                    chk("mem_we", {31'd0, memif.mem_we}, {31'd0, is_st});
                    if (is_st) chk("mem_wdata", memif.mem_wdata, exp_wd);
                end
                if (req_n == wt) begin
                    memif.mem_ack = 1'b1;
                    memif.mem_rdata = word;
                    if (is_st) begin
                        v = word;
                        for (int i = 0; i < 4; i++) if (exp_be[i]) v[8*i +: 8] = exp_wd[8*i +: 8];
                        mem_m[idx] = v;
                    end
                end
                req_n++;
            end
            if (opif.rsp_valid) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        memif.mem_ack = 1'b0;
        if (!done) begin
            chk("rsp_wait", 32'd0, 32'd1);
        end else begin
            last_rd = opif.rdata;
            chk("latency", cyc, exp_lat);
            chk("rdata", opif.rdata, exp_rd);
            chk("misalign", {31'd0, opif.misalign}, {31'd0, exp_mis});
            chk("err", {31'd0, opif.err}, {31'd0, exp_err});
            chk("req_cycles", req_n, exp_req);
            @(negedge clk);
            chk("rsp_pulse", {31'd0, opif.rsp_valid}, 32'd0);
            chk("rdata_clr", opif.rdata, 32'd0);
        end
    endtask

    initial begin
        logic [2:0]  t;
        logic [31:0] a;
        opif.op_valid = 1'b0; opif.op_type = 3'd0; opif.addr = 32'd0;
        opif.wdata = 32'd0; opif.pc = 32'd0;
        memif.mem_ack = 1'b0; memif.mem_rdata = 32'd0;
        mem_m[32'h8] = 32'h8081_f0f1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", {31'd0, opif.op_ready}, 32'd1);
        chk("rst_req", {31'd0, memif.mem_req}, 32'd0);
        chk("rst_be", {28'd0, memif.mem_be}, 32'd0);
        chk("rst_addr", memif.mem_addr, 32'd0);
        chk("rst_rsp", {31'd0, opif.rsp_valid}, 32'd0);
        chk("rst_flags", {30'd0, opif.misalign, opif.err}, 32'd0);

        run_op(T_SW, 32'h10, 32'hdead_beef, 0);
        run_op(T_LB, 32'h23, 32'h0, 0);   chk("lb_spec", last_rd, 32'hffff_ff80);
        run_op(T_LBU, 32'h23, 32'h0, 1);  chk("lbu_spec", last_rd, 32'h0000_0080);
        run_op(T_LH, 32'h22, 32'h0, 2);   chk("lh_spec", last_rd, 32'hffff_8081);
        run_op(T_LHU, 32'h20, 32'h0, 0);  chk("lhu_spec", last_rd, 32'h0000_f0f1);
        run_op(T_SH, 32'h6, 32'h1234_abcd, 0);
        run_op(T_LW, 32'h4, 32'h0, 0);    chk("sh_merge", last_rd & 32'hffff_0000, 32'habcd_0000);
        run_op(T_LW, 32'h2, 32'h0, 0);
        run_op(T_LW, 32'h4000, 32'h0, 0);
        run_op(T_LH, 32'h4001, 32'h0, 0);
        run_op(T_SB, 32'h3fff, 32'h0000_00a5, 4);
        run_op(T_LW, 32'h80, 32'h0, 5);

        for (int n = 0; n < 60; n++) begin
            t = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       a = $urandom_range(32'h3ff0, 32'h4010);
                1:       a = $urandom;
                default: a = $urandom_range(0, 32'h3f) * 4 + $urandom_range(0, 3);
            endcase
            run_op(t, a, $urandom, $urandom_range(0, 5));
        end

        // Reset while a request is outstanding
        @(negedge clk);
        opif.op_valid = 1'b1; opif.op_type = T_LW; opif.addr = 32'h100;
        @(negedge clk);
        opif.op_valid = 1'b0;
        chk("req_before_rst", {31'd0, memif.mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_req", {31'd0, memif.mem_req}, 32'd0);
        chk("rst_mid_ready", {31'd0, opif.op_ready}, 32'd1);
        chk("rst_mid_rsp", {31'd0, opif.rsp_valid}, 32'd0);
        run_op(T_LW, 32'h20, 32'h0, 0);   chk("after_rst", last_rd, 32'h8081_f0f1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
